// File: rtl/fetch_unit.sv
// fetch_unit: program counter, one-word instruction prefetch buffer, IR and
// combinational field decode. The sequencing FSM drives the control strobes.
// Optional feature: define FETCH_TIMEOUT_EN to add a memory-timeout watchdog
// that raises a sticky fetch_err; without it fetch_err is tied low and
// outstanding reads wait indefinitely.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        pc_rst,
    input  logic        pc_write,
    input  logic        pc_sel,
    input  logic        br_sel,
    input  logic        ir_load,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  opcode,
    output logic [3:0]  mm,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [15:0] imm,
    output logic [15:0] pc_out,
    output logic        stall,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2,
        FULL    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [31:0]        buf_q, buf_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic               mem_req_q, mem_req_d;
    logic               flush;
    logic               load_ok;
    logic signed [15:0] imm_s;
`ifdef FETCH_TIMEOUT_EN
    logic [3:0]         cnt_q, cnt_d;
    logic               fetch_err_q, fetch_err_d;
`endif

    // Any PC change makes the prefetched word stale.
    assign flush   = pc_write | pc_rst;
    // IR only accepts a word when one is actually buffered.
    assign load_ok = ir_load && (state_q == FULL);
    assign stall   = ir_load && (state_q != FULL);

    // Next PC: pc_rst beats pc_write beats hold; 16-bit adds wrap modulo 2^16.
    always_comb begin
        imm_s = ir_q[15:0];
        pc_d  = pc_q;
        if (pc_rst) begin
            pc_d = 16'h0000;
        end else if (pc_write) begin
            if (!pc_sel) begin
                pc_d = pc_q + 16'd1;
            end else if (br_sel) begin
                pc_d = ir_q[15:0];
            end else begin
                pc_d = $unsigned($signed(pc_q) + imm_s);
            end
        end
    end

    // Fetch FSM: issue one read per PC value, drop data made stale by a PC change.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        buf_d      = buf_q;
        ir_d       = load_ok ? buf_q : ir_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A PC change this cycle would make the address stale; wait one more cycle.
                if (!flush) begin
                    state_d    = BUSY;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d      = 4'd0;
`endif
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        buf_d   = mem_rdata;
                        state_d = FULL;
                    end
                end else if (flush) begin
                    // Read must still complete at the old address before refetching.
                    state_d = DISCARD;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            FULL: begin
                if (flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef FETCH_TIMEOUT_EN
        // Watchdog: count request cycles without ack; the 15th gives up.
        if (mem_req_q && !mem_ack) begin
            if (cnt_q == 4'd14) begin
                cnt_d       = 4'd15;
                fetch_err_d = 1'b1;
                mem_req_d   = 1'b0;
                state_d     = IDLE;
            end else if (!(state_q == BUSY && flush)) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
`endif
    end

    // Control and architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q    <= IDLE;
            pc_q       <= 16'h0000;
            ir_q       <= 32'h0000_0000;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= 4'd0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    // Prefetch buffer is pure data; its validity is carried by the FSM state.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign pc_out   = pc_q;
    assign opcode   = ir_q[31:28];
    assign mm       = ir_q[27:24];
    assign rd       = ir_q[23:20];
    assign rs       = ir_q[19:16];
    assign rt       = ir_q[15:12];
    assign imm      = ir_q[15:0];
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
